// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider, signed or unsigned per
// request. Retires BITS_PER_CYCLE quotient bits per CALC cycle, then applies
// sign correction in a single FIX cycle and pulses done.
module seq_divider #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
            (WIDTH % BITS_PER_CYCLE) != 0 || WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_params
            $error("seq_divider: illegal WIDTH/BITS_PER_CYCLE combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;        // partial remainder, one guard bit for the shift
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] r_quo;        // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] r_dvs;        // divisor magnitude
    logic [WIDTH-1:0] r_dvd_raw;    // untouched dividend, returned as remainder on /0
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_zero;

    // Two's-complement negate when en is set.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

    // Magnitude of x, taking abs only for signed requests.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
        return neg_if(x, is_signed & x[WIDTH-1]);
    endfunction

    assign busy = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; a zero divisor bypasses the iteration entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (divisor == '0) ? S_FIX : S_CALC;
            S_CALC:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // BITS_PER_CYCLE restoring shift/compare/subtract steps, MSB first.
    always_comb begin
        w_rem_nxt = r_rem;
        w_quo_nxt = r_quo;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_rem_nxt = {w_rem_nxt[WIDTH-1:0], w_quo_nxt[WIDTH-1]};
            w_quo_nxt = {w_quo_nxt[WIDTH-2:0], 1'b0};
            if (w_rem_nxt >= {1'b0, r_dvs}) begin
                w_rem_nxt    = w_rem_nxt - {1'b0, r_dvs};
                w_quo_nxt[0] = 1'b1;
            end
        end
    end

    // Operand capture, iteration registers and result/flag outputs.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_dvd_raw   <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_zero      <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvs       <= mag(divisor, signed_op);
                        r_quo       <= mag(dividend, signed_op);
                        r_rem       <= '0;
                        r_cnt       <= CNT_W'(N);
                        r_neg_q     <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r     <= signed_op & dividend[WIDTH-1];
                        r_zero      <= (divisor == '0);
                        r_dvd_raw   <= dividend;
                        div_by_zero <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= r_zero;
                    if (r_zero) begin
                        quotient  <= '1;
                        remainder <= r_dvd_raw;
                    end else begin
                        // MIN / -1 lands on MIN naturally: |MIN| / 1 with no negation.
                        quotient  <= neg_if(r_quo, r_neg_q);
                        remainder <= neg_if(r_rem[WIDTH-1:0], r_neg_r);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed bench for seq_divider. Instance A (defaults) is
// tracked every cycle by a behavioural model; instance B (BITS_PER_CYCLE = 2)
// is checked against hand-computed literals.
module tb_seq_divider;

    localparam int A_EDGES = 32 / 1 + 1;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;

    logic        busy_a, done_a, z_a;
    logic [31:0] q_a, r_a;
    logic        busy_b, done_b, z_b;
    logic [31:0] q_b, r_b;

    int n_tot  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    seq_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_a (
        .Clock(Clock), .Clear(Clear), .start(start_a), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy_a), .done(done_a),
        .quotient(q_a), .remainder(r_a), .div_by_zero(z_a)
    );

    seq_divider #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut_b (
        .Clock(Clock), .Clear(Clear), .start(start_b), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy_b), .done(done_b),
        .quotient(q_b), .remainder(r_b), .div_by_zero(z_b)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference result {div_by_zero, quotient, remainder} from plain arithmetic.
    function automatic logic [64:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, q, r};
    endfunction

    // Behavioural model of instance A: accept when idle, result appears after a fixed edge count.
    logic        m_busy, m_done, m_z;
    logic [31:0] m_q, m_r;
    logic [64:0] p_res;
    int          m_left;

    always @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_z <= 1'b0;
            m_q <= '0; m_r <= '0; p_res <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start_a) begin
                    m_busy <= 1'b1;
                    m_z    <= 1'b0;
                    p_res  <= ref_div(signed_op, dividend, divisor);
                    m_left <= (divisor == 32'd0) ? 1 : A_EDGES;
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                {m_z, m_q, m_r} <= p_res;
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge Clock) begin
        if (cmp_en) begin
            chk("A.busy", 32'(busy_a), 32'(m_busy));
            chk("A.done", 32'(done_a), 32'(m_done));
            chk("A.quotient", q_a, m_q);
            chk("A.remainder", r_a, m_r);
            chk("A.div_by_zero", 32'(z_a), 32'(m_z));
        end
    end

    // One request on instance sel; optionally re-pulses start (with other operands) at cycle poke.
    task automatic run(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input int poke, output int lat, output int bcnt);
        @(negedge Clock);
        signed_op = s; dividend = a; divisor = b;
        start_a = (sel == 0); start_b = (sel == 1);
        @(negedge Clock);
        start_a = 1'b0; start_b = 1'b0;
        dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0003;
        lat  = 0;
        bcnt = (sel ? busy_b : busy_a) ? 1 : 0;
        while (!(sel ? done_b : done_a) && lat < 100) begin
            start_a = (sel == 0) && (lat == poke);
            start_b = (sel == 1) && (lat == poke);
            if (lat == poke) begin dividend = 32'h5; divisor = 32'h1; end
            @(negedge Clock);
            start_a = 1'b0; start_b = 1'b0;
            lat++;
            if (sel ? busy_b : busy_a) bcnt++;
        end
        chk("done_seen", 32'(sel ? done_b : done_a), 32'd1);
    endtask

    int lat, bc;

    initial begin
        repeat (2) @(negedge Clock);
        Clear = 1'b0;
        chk("rst.busy_a", 32'(busy_a), 0);
        chk("rst.done_a", 32'(done_a), 0);
        chk("rst.q_a", q_a, 0);
        chk("rst.r_a", r_a, 0);
        chk("rst.z_a", 32'(z_a), 0);
        chk("rst.busy_b", 32'(busy_b), 0);
        cmp_en = 1'b1;

        run(0, 1'b0, 32'h12, 32'h14, -1, lat, bc);
        chk("u18/20.lat", lat, 33);
        chk("u18/20.busy_cycles", bc, 33);
        chk("u18/20.q", q_a, 32'h0);
        chk("u18/20.r", r_a, 32'h12);

        run(0, 1'b1, 32'hFFFF_FFF9, 32'h2, 5, lat, bc);
        chk("s-7/2.lat", lat, 33);
        chk("s-7/2.q", q_a, 32'hFFFF_FFFD);
        chk("s-7/2.r", r_a, 32'hFFFF_FFFF);

        run(0, 1'b0, 32'hFFFF_FFF9, 32'h2, -1, lat, bc);
        chk("u-7/2.q", q_a, 32'h7FFF_FFFC);
        chk("u-7/2.r", r_a, 32'h1);

        run(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bc);
        chk("min/-1.q", q_a, 32'h8000_0000);
        chk("min/-1.r", r_a, 32'h0);
        chk("min/-1.z", 32'(z_a), 0);

        run(0, 1'b0, 32'h18, 32'h0, -1, lat, bc);
        chk("div0.lat", lat, 1);
        chk("div0.q", q_a, 32'hFFFF_FFFF);
        chk("div0.r", r_a, 32'h18);
        chk("div0.z", 32'(z_a), 1);

        run(0, 1'b1, 32'hFFFF_FF00, 32'h0, -1, lat, bc);
        chk("sdiv0.r", r_a, 32'hFFFF_FF00);
        chk("sdiv0.z", 32'(z_a), 1);

        // Accept a request, confirm the flag drops, then abort it with Clear.
        @(negedge Clock);
        signed_op = 1'b0; dividend = 32'd12345; divisor = 32'd77; start_a = 1'b1;
        @(negedge Clock);
        start_a = 1'b0;
        chk("next_start.z_cleared", 32'(z_a), 0);
        chk("next_start.busy", 32'(busy_a), 1);
        repeat (9) @(negedge Clock);
        #2 Clear = 1'b1;
        #1;
        chk("clr.busy", 32'(busy_a), 0);
        chk("clr.done", 32'(done_a), 0);
        chk("clr.q", q_a, 0);
        chk("clr.r", r_a, 0);
        chk("clr.z", 32'(z_a), 0);
        #1 Clear = 1'b0;

        run(0, 1'b0, 32'd100, 32'd7, -1, lat, bc);
        chk("100/7.q", q_a, 32'h0000_000E);
        chk("100/7.r", r_a, 32'h0000_0002);

        run(0, 1'b1, 32'd100, 32'hFFFF_FFF9, -1, lat, bc);
        chk("100/-7.q", q_a, 32'hFFFF_FFF2);
        chk("100/-7.r", r_a, 32'h2);

        run(1, 1'b0, 32'h1234_5678, 32'h0000_1234, 3, lat, bc);
        chk("B.lat", lat, 17);
        chk("B.busy_cycles", bc, 17);
        chk("B.q", q_b, 32'h0001_0004);
        chk("B.r", r_b, 32'h0000_0DA8);
        repeat (3) @(negedge Clock);
        chk("B.no_queued_start", 32'(busy_b), 0);
        chk("B.q_held", q_b, 32'h0001_0004);

        run(1, 1'b1, 32'hFFFF_FFF9, 32'h2, -1, lat, bc);
        chk("B.s-7/2.lat", lat, 17);
        chk("B.s-7/2.q", q_b, 32'hFFFF_FFFD);
        chk("B.s-7/2.r", r_b, 32'hFFFF_FFFF);

        run(1, 1'b0, 32'h55, 32'h0, -1, lat, bc);
        chk("B.div0.lat", lat, 1);
        chk("B.div0.z", 32'(z_b), 1);

        @(negedge Clock);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
